blink_sseg_scan: RTL and testbench

Time-multiplexed, parametrised seven-segment display driver for multi-digit common-anode displays. It takes `NUM_DIGITS` hex nibbles and scans one digit at a time onto a shared segment bus. Per-digit controls cover blank, blink and decimal point, and a guard interval between digits suppresses ghosting. It sits between the Mealy/FSM logic that produces the display values and the board's `seg`/`dp`/`an` pins, and replaces one-decoder-per-digit wiring.

---
 rtl/blink_sseg_scan_pkg.sv | 21 ++
 rtl/blink_sseg_scan_if.sv | 25 ++
 rtl/blink_sseg_scan_decode.sv | 18 +
 rtl/blink_sseg_scan.sv | 102 ++++++++++
 tb/tb_blink_sseg_scan.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/blink_sseg_scan_pkg.sv
// Shared types and the hex-to-segment table for the scanned seven-segment driver.
// Segment vectors are active-low and ordered {a,b,c,d,e,f,g}.
package blink_sseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'b1111111;

   localparam seg_t HEX_SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/blink_sseg_scan_if.sv
// Display-side bundle: values and masks from the producer, segment/anode pins back.
interface blink_sseg_scan_if #(
   parameter int NUM_DIGITS = 4
);
   import blink_sseg_pkg::*;

   logic                    en;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [NUM_DIGITS-1:0]   dp_mask;
   seg_t                    seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;

   modport master (
      output en, digits, blank_mask, blink_mask, dp_mask,
      input  seg, dp, an
   );

   modport slave (
      input  en, digits, blank_mask, blink_mask, dp_mask,
      output seg, dp, an
   );
endinterface

// File: rtl/blink_sseg_scan_decode.sv
// Combinational hex nibble to active-low segment decode; undefined nibbles stay dark.
module sseg_hex_decode
   import blink_sseg_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);

   // NOTE: seg gets a default before the search so no path leaves it unassigned (no latch);
   // an X nibble matches no entry and falls through to SEG_OFF.
   always_comb begin
      seg = SEG_OFF;
      for (int k = 0; k < 16; k++) begin
         if (nib == 4'(k)) seg = HEX_SEG[k];
      end
   end

endmodule

// File: rtl/blink_sseg_scan.sv
// Time-multiplexed multi-digit seven-segment driver with per-digit blank, blink,
// decimal point and an anode-off guard at the start of every digit slot.
module blink_sseg_scan
   import blink_sseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 2000,
   parameter int BLINK_DIV    = 25000000
) (
   input logic              clk,
   input logic              rst_n,
   blink_sseg_scan_if.slave bus
);

   localparam int RW = cnt_w(REFRESH_DIV);
   localparam int IW = cnt_w(NUM_DIGITS);
   localparam int BW = cnt_w(BLINK_DIV);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("blink_sseg_scan: NUM_DIGITS must be 1..8");
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh
      $error("blink_sseg_scan: REFRESH_DIV must be at least 2");
   end
   if (GUARD_CYCLES < 0 || GUARD_CYCLES >= REFRESH_DIV) begin : g_bad_guard
      $error("blink_sseg_scan: GUARD_CYCLES must be below REFRESH_DIV");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink
      $error("blink_sseg_scan: BLINK_DIV must be at least 1");
   end

   logic [RW-1:0]         refresh_cnt;
   logic [IW-1:0]         scan_idx;
   logic [BW-1:0]         blink_cnt;
   logic                  blink_on;

   logic [3:0]            nib;
   seg_t                  seg_dec;
   logic                  lit;
   seg_t                  seg_q;
   logic                  dp_q;
   logic [NUM_DIGITS-1:0] an_q;

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
         scan_idx    <= '0;
         blink_cnt   <= '0;
         blink_on    <= 1'b1;
      end else begin
         if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
         end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
         end

         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign nib = bus.digits[4*int'(scan_idx) +: 4];

   sseg_hex_decode u_decode (
      .nib (nib),
      .seg (seg_dec)
   );

   assign lit = bus.en
              & ~bus.blank_mask[scan_idx]
              & (blink_on | ~bus.blink_mask[scan_idx])
              & (refresh_cnt >= RW'(GUARD_CYCLES));

   // Pins are registered so that reset darkens them immediately and no input reaches them combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_OFF;
         dp_q  <= 1'b1;
         an_q  <= '1;
      end else if (lit) begin
         seg_q <= seg_dec;
         dp_q  <= ~bus.dp_mask[scan_idx];
         an_q  <= ~(NUM_DIGITS'(1) << scan_idx);
      end else begin
         seg_q <= SEG_OFF;
         dp_q  <= 1'b1;
         an_q  <= '1;
      end
   end

   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.an  = an_q;

endmodule

// File: tb/tb_blink_sseg_scan.sv
// Directed bench for blink_sseg_scan at NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, BLINK_DIV=16.
// Edge n (1 = first edge after reset release) samples refresh=(n-1)%4, digit=((n-1)/4)%4, blink_on=even((n-1)/16).
module tb_blink_sseg_scan;

   localparam int ND = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   blink_sseg_scan_if #(.NUM_DIGITS(ND)) bif ();

   blink_sseg_scan #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (4),
      .GUARD_CYCLES (1),
      .BLINK_DIV    (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL timeout: bench still running at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;  default: return 7'b0111000;
      endcase
   endfunction

   task automatic check_dark(input string tag);
      check({tag, " an"},  32'(bif.an),  32'hF);
      check({tag, " seg"}, 32'(bif.seg), 32'h7F);
      check({tag, " dp"},  32'(bif.dp),  32'h1);
   endtask

   // Sets masks, holds reset with en=1, checks the dark state, releases at a falling edge.
   task automatic do_reset(input string tag, input logic [3:0] blank,
                           input logic [3:0] blink, input logic [3:0] dpm);
      @(negedge clk);
      rst_n          = 1'b0;
      bif.en         = 1'b1;
      bif.digits     = 16'h1A3F;
      bif.blank_mask = blank;
      bif.blink_mask = blink;
      bif.dp_mask    = dpm;
      repeat (2) @(negedge clk);
      check_dark({tag, " in reset"});
      rst_n = 1'b1;
   endtask

   // Steps edges n_first..n_last, with en low for edges off_lo..off_hi, checking every edge.
   task automatic run_edges(input string tag, input int n_first, input int n_last,
                            input int off_lo, input int off_hi);
      for (int n = n_first; n <= n_last; n++) begin
         int         r;
         int         idx;
         logic       bon;
         logic       en_n;
         logic       lit;
         logic [3:0] e_an;
         logic [6:0] e_seg;
         logic       e_dp;
         en_n   = !(n >= off_lo && n <= off_hi);
         bif.en = en_n;
         r   = (n - 1) % 4;
         idx = ((n - 1) / 4) % 4;
         bon = (((n - 1) / 16) % 2) == 0;
         lit = en_n && !bif.blank_mask[idx] && (bon || !bif.blink_mask[idx]) && (r >= 1);
         e_an  = lit ? ~(4'b0001 << idx) : 4'b1111;
         e_seg = lit ? hex_seg(bif.digits[4*idx +: 4]) : 7'b1111111;
         e_dp  = lit ? ~bif.dp_mask[idx] : 1'b1;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("%s e%0d an", tag, n),  32'(bif.an),  32'(e_an));
         check($sformatf("%s e%0d seg", tag, n), 32'(bif.seg), 32'(e_seg));
         check($sformatf("%s e%0d dp", tag, n),  32'(bif.dp),  32'(e_dp));
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_bad          = 0;
      rst_n          = 1'b0;
      bif.en         = 1'b1;
      bif.digits     = 16'h1A3F;
      bif.blank_mask = '0;
      bif.blink_mask = '0;
      bif.dp_mask    = '0;

      // Reset, first anode at edge 2, then plain scan over two frames.
      do_reset("rst", 4'b0000, 4'b0000, 4'b0000);
      @(posedge clk); @(negedge clk);
      check("rst edge1 an", 32'(bif.an), 32'b1111);
      @(posedge clk); @(negedge clk);
      check("rst edge2 an", 32'(bif.an), 32'b1110);
      check("rst edge2 seg F", 32'(bif.seg), 32'b0111000);
      run_edges("scan", 3, 32, 0, -1);

      // Blink on digit 0: shown edges 1-16, dark 17-32, shown again 33-48.
      do_reset("blink", 4'b0000, 4'b0001, 4'b0000);
      run_edges("blink", 1, 64, 0, -1);

      // Digit 2 blanked, decimal point on digit 1.
      do_reset("blank", 4'b0100, 4'b0000, 4'b0010);
      run_edges("blank", 1, 32, 0, -1);

      // Enable dropped for edges 10..15; counters keep running underneath.
      do_reset("en", 4'b0000, 4'b0000, 4'b0000);
      run_edges("en", 1, 24, 10, 15);

      // Asynchronous reset while digit 2 is lit, then restart at digit 0.
      do_reset("mid", 4'b0000, 4'b0000, 4'b0000);
      run_edges("mid", 1, 10, 0, -1);
      check("mid pre-reset an", 32'(bif.an), 32'b1011);
      rst_n = 1'b0;
      #1;
      check_dark("mid async");
      @(negedge clk);
      rst_n = 1'b1;
      run_edges("mid restart", 1, 8, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
